// File: rtl/hpi_pkg.sv
// Shared types and constants for the CY7C67200 Host Port Interface sequencer.
package hpi_pkg;

  localparam int HPI_NPORTS = 2;

  // HPI register addresses presented on OTG_ADDR.
  localparam logic [1:0] HPI_ADDR_DATA    = 2'd0;
  localparam logic [1:0] HPI_ADDR_MAILBOX = 2'd1;
  localparam logic [1:0] HPI_ADDR_ADDRESS = 2'd2;
  localparam logic [1:0] HPI_ADDR_STATUS  = 2'd3;

  typedef enum logic [2:0] {
    RST_HOLD,
    IDLE,
    SETUP,
    STROBE,
    HOLD,
    RECOVER
  } hpi_state_e;

  // Port index to one-hot per-port vector.
  function automatic logic [HPI_NPORTS-1:0] port_onehot(input logic port);
    return port ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter: a lone requester always wins, a tie goes to
// the port that was not granted last. Purely combinational.
module rr_arbiter2 (
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic [1:0] grant
);

  // Pick the winner for this cycle.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no path leaves it unassigned and infers a latch.
    grant = 2'b00;
    case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = last_grant ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/hpi_bus_arbiter.sv
// Shares the CY7C67200 HPI between the software bridge (port 0) and the
// keycode poller (port 1), generating chip reset and strobe timing. Every
// pin, including the data output enable, is driven from a flop.
module hpi_bus_arbiter
  import hpi_pkg::*;
#(
  parameter int SETUP_CYC  = 1,
  parameter int STROBE_CYC = 4,
  parameter int HOLD_CYC   = 1,
  parameter int RST_CYC    = 16
) (
  input  logic                             Clk,
  input  logic                             Reset,
  input  logic [HPI_NPORTS-1:0]            req_valid,
  input  logic [HPI_NPORTS-1:0]            req_write,
  input  logic [HPI_NPORTS-1:0][1:0]       req_addr,
  input  logic [HPI_NPORTS-1:0][15:0]      req_wdata,
  output logic [HPI_NPORTS-1:0]            req_ready,
  output logic [HPI_NPORTS-1:0]            req_done,
  output logic [15:0]                      rdata,
  output logic                             int_sync,
  inout  wire  [15:0]                      OTG_DATA,
  output logic [1:0]                       OTG_ADDR,
  output logic                             OTG_CS_N,
  output logic                             OTG_RD_N,
  output logic                             OTG_WR_N,
  output logic                             OTG_RST_N,
  input  logic                             OTG_INT
);

  localparam int MAX_PH = (SETUP_CYC > STROBE_CYC) ?
                          ((SETUP_CYC > HOLD_CYC) ? SETUP_CYC : HOLD_CYC) :
                          ((STROBE_CYC > HOLD_CYC) ? STROBE_CYC : HOLD_CYC);
  localparam int PH_W  = $clog2(MAX_PH) + 1;
  localparam int RST_W = $clog2(RST_CYC) + 1;

  hpi_state_e       state_q, state_d;
  logic [PH_W-1:0]  ph_cnt_q, ph_cnt_d;
  logic [RST_W-1:0] rst_cnt_q, rst_cnt_d;
  logic             last_grant_q, last_grant_d;
  logic             port_q, port_d;
  logic             write_q, write_d;
  logic [1:0]       addr_q, addr_d;
  logic [15:0]      wdata_q, wdata_d;
  logic [15:0]      rdata_q, rdata_d;

  logic             cs_n_q, cs_n_d;
  logic             rd_n_q, rd_n_d;
  logic             wr_n_q, wr_n_d;
  logic             otg_rst_n_q, otg_rst_n_d;
  logic             data_oe_q, data_oe_d;
  logic [HPI_NPORTS-1:0] done_q, done_d;
  logic             int_meta_q, int_sync_q;
  logic             busy_d;
  logic [HPI_NPORTS-1:0] grant;

  rr_arbiter2 u_arb (
    .req        (req_valid),
    .last_grant (last_grant_q),
    .grant      (grant)
  );

  // Sequencer next state, transaction capture and registered pin values.
  always_comb begin
    state_d      = state_q;
    ph_cnt_d     = ph_cnt_q;
    rst_cnt_d    = rst_cnt_q;
    last_grant_d = last_grant_q;
    port_d       = port_q;
    write_d      = write_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    rdata_d      = rdata_q;
    req_ready    = '0;

    case (state_q)
      RST_HOLD: begin
        if (rst_cnt_q == RST_W'(RST_CYC - 1)) state_d = IDLE;
        else                                  rst_cnt_d = rst_cnt_q + RST_W'(1);
      end
      IDLE: begin
        req_ready = grant;
        if (|grant) begin
          port_d       = grant[1];
          write_d      = req_write[grant[1]];
          addr_d       = req_addr[grant[1]];
          wdata_d      = req_wdata[grant[1]];
          last_grant_d = grant[1];
          ph_cnt_d     = PH_W'(SETUP_CYC - 1);
          state_d      = SETUP;
        end
      end
      SETUP: begin
        if (ph_cnt_q == '0) begin
          ph_cnt_d = PH_W'(STROBE_CYC - 1);
          state_d  = STROBE;
        end else begin
          ph_cnt_d = ph_cnt_q - PH_W'(1);
        end
      end
      STROBE: begin
        if (ph_cnt_q == '0) begin
          // The read strobe is still low in this cycle, so the chip is driving.
          if (!write_q) rdata_d = OTG_DATA;
          ph_cnt_d = PH_W'(HOLD_CYC - 1);
          state_d  = HOLD;
        end else begin
          ph_cnt_d = ph_cnt_q - PH_W'(1);
        end
      end
      HOLD: begin
        if (ph_cnt_q == '0) state_d = RECOVER;
        else                ph_cnt_d = ph_cnt_q - PH_W'(1);
      end
      RECOVER: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Pins are decoded from the state being entered so they land in a flop.
    busy_d      = (state_d == SETUP) || (state_d == STROBE) || (state_d == HOLD);
    cs_n_d      = !busy_d;
    rd_n_d      = !((state_d == STROBE) && !write_d);
    wr_n_d      = !((state_d == STROBE) && write_d);
    data_oe_d   = busy_d && write_d;
    otg_rst_n_d = (state_d != RST_HOLD);
    done_d      = (state_d == RECOVER) ? port_onehot(port_q) : '0;
  end

  // All sequencer state and HPI pin registers.
  always_ff @(posedge Clk or negedge Reset) begin
    // NOTE: the asynchronous reset puts the pins in their safe idle levels at once, without waiting for a clock edge.
    if (!Reset) begin
      state_q      <= RST_HOLD;
      ph_cnt_q     <= '0;
      rst_cnt_q    <= '0;
      last_grant_q <= 1'b1;
      port_q       <= 1'b0;
      write_q      <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      rdata_q      <= '0;
      cs_n_q       <= 1'b1;
      rd_n_q       <= 1'b1;
      wr_n_q       <= 1'b1;
      otg_rst_n_q  <= 1'b0;
      data_oe_q    <= 1'b0;
      done_q       <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values regardless of statement order.
      state_q      <= state_d;
      ph_cnt_q     <= ph_cnt_d;
      rst_cnt_q    <= rst_cnt_d;
      last_grant_q <= last_grant_d;
      port_q       <= port_d;
      write_q      <= write_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      rdata_q      <= rdata_d;
      cs_n_q       <= cs_n_d;
      rd_n_q       <= rd_n_d;
      wr_n_q       <= wr_n_d;
      otg_rst_n_q  <= otg_rst_n_d;
      data_oe_q    <= data_oe_d;
      done_q       <= done_d;
    end
  end

  // Two-flop synchronizer for the asynchronous chip interrupt.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      int_meta_q <= 1'b0;
      int_sync_q <= 1'b0;
    end else begin
      int_meta_q <= OTG_INT;
      int_sync_q <= int_meta_q;
    end
  end

  assign OTG_DATA  = data_oe_q ? wdata_q : 'z;
  assign OTG_ADDR  = addr_q;
  assign OTG_CS_N  = cs_n_q;
  assign OTG_RD_N  = rd_n_q;
  assign OTG_WR_N  = wr_n_q;
  assign OTG_RST_N = otg_rst_n_q;
  assign req_done  = done_q;
  assign rdata     = rdata_q;
  assign int_sync  = int_sync_q;

endmodule

// File: tb/tb_hpi_bus_arbiter.sv
// Directed bench for hpi_bus_arbiter with default timing parameters.
module tb_hpi_bus_arbiter;
  import hpi_pkg::*;

  typedef struct {
    int          cs_cnt;
    int          cs_first;
    int          wr_cnt;
    int          wr_first;
    int          rd_cnt;
    int          rd_first;
    int          done_k;
    int          done_cnt;
    logic [1:0]  done_val;
    logic        bus_ok;
    logic [15:0] rdata_at_done;
  } txn_obs_t;

  logic             clk = 1'b0;
  logic             reset;
  logic [1:0]       req_valid;
  logic [1:0]       req_write;
  logic [1:0][1:0]  req_addr;
  logic [1:0][15:0] req_wdata;
  logic [1:0]       req_ready;
  logic [1:0]       req_done;
  logic [15:0]      rdata;
  logic             int_sync;
  wire  [15:0]      otg_data;
  logic [1:0]       otg_addr;
  logic             otg_cs_n, otg_rd_n, otg_wr_n, otg_rst_n;
  logic             otg_int;
  logic             tb_drv_en;
  logic [15:0]      tb_drv_val;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  assign otg_data = tb_drv_en ? tb_drv_val : 'z;

  hpi_bus_arbiter dut (
    .Clk       (clk),
    .Reset     (reset),
    .req_valid (req_valid),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_ready (req_ready),
    .req_done  (req_done),
    .rdata     (rdata),
    .int_sync  (int_sync),
    .OTG_DATA  (otg_data),
    .OTG_ADDR  (otg_addr),
    .OTG_CS_N  (otg_cs_n),
    .OTG_RD_N  (otg_rd_n),
    .OTG_WR_N  (otg_wr_n),
    .OTG_RST_N (otg_rst_n),
    .OTG_INT   (otg_int)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Bus not driven by anyone: reads as z in 4-state, 0 in 2-state.
  function automatic logic released(input logic [15:0] v);
    return (v === 16'hzzzz) || (v === 16'h0000);
  endfunction

  // Called at a negedge just after reset release; expects 16 low cycles.
  task automatic count_rst_low(input string tag);
    int   low = 0;
    logic bad = 1'b0;
    for (int i = 0; i < 40; i++) begin
      #1;
      if (otg_rst_n) break;
      low++;
      if (req_ready != 2'b00 || !otg_cs_n || !otg_rd_n || !otg_wr_n) bad = 1'b1;
      @(negedge clk);
    end
    check($sformatf("%s_rst_low_cycles", tag), low, 16);
    check($sformatf("%s_quiet_in_rst", tag), bad, 1'b0);
    check($sformatf("%s_rst_n_high", tag), otg_rst_n, 1'b1);
  endtask

  // Called in IDLE; presents a request, checks ready, crosses the acceptance edge.
  task automatic launch(input string tag, input logic [1:0] valid,
                        input logic [1:0] exp_ready, input logic keep);
    req_valid = valid;
    #1;
    check($sformatf("%s_ready", tag), req_ready, exp_ready);
    @(posedge clk);
    #1;
    if (!keep) req_valid = 2'b00;
  endtask

  // Observes the 8 cycles after acceptance (k = 1 is the first SETUP cycle).
  task automatic watch_txn(input logic [1:0] exp_addr, input logic [15:0] exp_data,
                           output txn_obs_t o);
    o = '{default: '0};
    o.bus_ok = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (!otg_cs_n) begin
        o.cs_cnt++;
        if (o.cs_first == 0) o.cs_first = k;
        if (otg_addr !== exp_addr || otg_data !== exp_data) o.bus_ok = 1'b0;
      end
      if (!otg_wr_n) begin
        o.wr_cnt++;
        if (o.wr_first == 0) o.wr_first = k;
      end
      if (!otg_rd_n) begin
        o.rd_cnt++;
        if (o.rd_first == 0) o.rd_first = k;
      end
      if (req_done != 2'b00) begin
        o.done_cnt++;
        if (o.done_k == 0) begin
          o.done_k        = k;
          o.done_val      = req_done;
          o.rdata_at_done = rdata;
        end
      end
    end
  endtask

  task automatic check_txn(input string tag, input txn_obs_t o,
                           input logic is_write, input logic [1:0] exp_done);
    check($sformatf("%s_cs_cycles", tag), o.cs_cnt, 6);
    check($sformatf("%s_cs_first", tag), o.cs_first, 1);
    check($sformatf("%s_wr_cycles", tag), o.wr_cnt, is_write ? 4 : 0);
    check($sformatf("%s_rd_cycles", tag), o.rd_cnt, is_write ? 0 : 4);
    check($sformatf("%s_strobe_first", tag), is_write ? o.wr_first : o.rd_first, 2);
    check($sformatf("%s_done_cycle", tag), o.done_k, 7);
    check($sformatf("%s_done_pulses", tag), o.done_cnt, 1);
    check($sformatf("%s_done_port", tag), o.done_val, exp_done);
    check($sformatf("%s_bus", tag), o.bus_ok, 1'b1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    txn_obs_t   o;
    int         n;
    logic       flag;
    logic [1:0] ct_ready [4];
    logic [1:0] ct_addr  [4];
    logic [15:0] ct_data [4];

    reset      = 1'b0;
    req_valid  = 2'b11;
    req_write  = 2'b00;
    req_addr   = '0;
    req_wdata  = '0;
    tb_drv_en  = 1'b0;
    tb_drv_val = 16'h0000;
    otg_int    = 1'b0;

    // Reset state, with both requests pending.
    repeat (5) @(negedge clk);
    check("rst_cs_n", otg_cs_n, 1'b1);
    check("rst_rd_n", otg_rd_n, 1'b1);
    check("rst_wr_n", otg_wr_n, 1'b1);
    check("rst_otg_rst_n", otg_rst_n, 1'b0);
    check("rst_addr", otg_addr, 2'd0);
    check("rst_ready", req_ready, 2'b00);
    check("rst_done", req_done, 2'b00);
    check("rst_rdata", rdata, 16'h0000);
    check("rst_int_sync", int_sync, 1'b0);
    check("rst_data_z", released(otg_data), 1'b1);

    reset = 1'b1;
    count_rst_low("rel");
    req_valid = 2'b00;

    // Single write from port 0.
    req_write[0] = 1'b1;
    req_addr[0]  = HPI_ADDR_ADDRESS;
    req_wdata[0] = 16'h1234;
    launch("wr0", 2'b01, 2'b01, 1'b0);
    watch_txn(HPI_ADDR_ADDRESS, 16'h1234, o);
    check_txn("wr0", o, 1'b1, 2'b01);
    check("wr0_rdata_untouched", o.rdata_at_done, 16'h0000);

    // Single read from port 1 while the chip drives BEEF.
    req_write[1] = 1'b0;
    req_addr[1]  = HPI_ADDR_DATA;
    tb_drv_val   = 16'hBEEF;
    tb_drv_en    = 1'b1;
    launch("rd1", 2'b10, 2'b10, 1'b0);
    watch_txn(HPI_ADDR_DATA, 16'hBEEF, o);
    check_txn("rd1", o, 1'b0, 2'b10);
    check("rd1_rdata", o.rdata_at_done, 16'hBEEF);
    tb_drv_en = 1'b0;

    // Contention: both ports write continuously; last grant was port 1.
    req_write    = 2'b11;
    req_addr[0]  = HPI_ADDR_MAILBOX;
    req_wdata[0] = 16'h1111;
    req_addr[1]  = HPI_ADDR_STATUS;
    req_wdata[1] = 16'h2222;
    ct_ready = '{2'b01, 2'b10, 2'b01, 2'b10};
    ct_addr  = '{HPI_ADDR_MAILBOX, HPI_ADDR_STATUS, HPI_ADDR_MAILBOX, HPI_ADDR_STATUS};
    ct_data  = '{16'h1111, 16'h2222, 16'h1111, 16'h2222};
    for (int i = 0; i < 4; i++) begin
      launch($sformatf("ct%0d", i), 2'b11, ct_ready[i], 1'b1);
      watch_txn(ct_addr[i], ct_data[i], o);
      check_txn($sformatf("ct%0d", i), o, 1'b1, ct_ready[i]);
    end
    req_valid = 2'b00;
    check("ct_rdata_held", rdata, 16'hBEEF);

    // Interrupt synchronizer.
    @(posedge clk);
    #3;
    otg_int = 1'b1;
    check("int_before", int_sync, 1'b0);
    n = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      n++;
      if (int_sync) break;
    end
    check("int_lag_2to3", (n >= 2) && (n <= 3), 1'b1);
    flag = 1'b1;
    repeat (5) begin
      @(negedge clk);
      if (!int_sync) flag = 1'b0;
    end
    check("int_holds", flag, 1'b1);
    otg_int = 1'b0;
    repeat (3) @(negedge clk);
    check("int_falls", int_sync, 1'b0);

    // Reset asserted in the second STROBE cycle of a write.
    req_write[0] = 1'b1;
    req_addr[0]  = HPI_ADDR_ADDRESS;
    req_wdata[0] = 16'hCAFE;
    launch("mid", 2'b01, 2'b01, 1'b1);
    @(negedge clk);
    @(negedge clk);
    @(posedge clk);
    #2;
    check("mid_wr_n_pre", otg_wr_n, 1'b0);
    check("mid_data_pre", otg_data, 16'hCAFE);
    reset = 1'b0;
    #1;
    check("mid_wr_n_async", otg_wr_n, 1'b1);
    check("mid_cs_n_async", otg_cs_n, 1'b1);
    check("mid_data_z_async", released(otg_data), 1'b1);
    check("mid_otg_rst_n", otg_rst_n, 1'b0);
    flag = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (req_done != 2'b00 || req_ready != 2'b00) flag = 1'b1;
    end
    check("mid_no_done", flag, 1'b0);
    reset = 1'b1;
    count_rst_low("mid");
    launch("post", 2'b01, 2'b01, 1'b0);
    watch_txn(HPI_ADDR_ADDRESS, 16'hCAFE, o);
    check_txn("post", o, 1'b1, 2'b01);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/hpi_bus_arbiter.md
# hpi_bus_arbiter

Sequences all accesses to the CY7C67200 Host Port Interface (OTG_DATA/ADDR/CS_N/RD_N/WR_N/RST_N) and shares that bus between two requesters: port 0 is the Nios II software bridge and port 1 is a hardware keycode poller. The block produces HPI strobe timing with programmable setup, strobe and hold counts. It arbitrates round-robin between the two ports and generates the chip reset pulse after system reset. It sits between `usb_system` / the poller and the OTG pins at the top level.

## Interface
- `SETUP_CYC`, default 1: cycles CS_N/ADDR/data are valid before the strobe (≥1).
- `STROBE_CYC`, default 4: cycles RD_N/WR_N are held low (≥1).
- `HOLD_CYC`, default 1: cycles CS_N/ADDR/data are held after the strobe (≥1).
- `RST_CYC`, default 16: cycles OTG_RST_N is held low after reset release (≥1).

- `Clk`  in  1  system clock, 50 MHz.
- `Reset`  in  1  asynchronous, active-low reset.
- `req_valid`  in  [1:0]  request pending, one bit per port.
- `req_write`  in  [1:0]  1 = write, 0 = read.
- `req_addr`  in  [1:0][1:0]  HPI register address per port.
- `req_wdata`  in  [1:0][15:0]  write data per port.
- `req_ready`  out  [1:0]  one-hot acceptance; the request transfers in the cycle where valid & ready are both high.
- `req_done`  out  [1:0]  one-cycle completion pulse to the owning port.
- `rdata`  out  16  read data; valid when `req_done` is high and held until the next read completes.
- `int_sync`  out  1  OTG_INT after a 2-FF synchronizer.
- `OTG_DATA`  inout  16  driven only during write transactions, otherwise `'z`.
- `OTG_ADDR`  out  2, `OTG_CS_N` out 1, `OTG_RD_N` out 1, `OTG_WR_N` out 1, `OTG_RST_N` out 1: HPI pins.
- `OTG_INT`  in  1  asynchronous chip interrupt.

## Operation
- States:
  - RST_HOLD → IDLE → SETUP → STROBE → HOLD → RECOVER → IDLE.
- RST_HOLD:
  - Entered asynchronously whenever `Reset` = 0. A counter is cleared while in reset.
  - After release, OTG_RST_N stays 0 for RST_CYC cycles, then goes 1 and the block enters IDLE.
- IDLE:
  - `req_ready` is combinational from `req_valid` and the arbiter.
  - If only one port is valid, it is granted.
  - If both ports are valid, the port ≠ `last_grant` wins.
  - On acceptance, the block registers port, write, addr and wdata, updates `last_grant`, and moves to SETUP.
- SETUP (SETUP_CYC cycles): CS_N = 0, ADDR driven; OTG_DATA driven if write.
- STROBE (STROBE_CYC cycles): RD_N = 0 for a read or WR_N = 0 for a write. For a read, OTG_DATA is captured into `rdata` on the clock edge that ends the last STROBE cycle.
- HOLD (HOLD_CYC cycles): strobes = 1; CS_N, ADDR and data are unchanged.
- RECOVER (1 cycle): CS_N = 1, data bus released, `req_done[port]` = 1. Next state is IDLE. Back-to-back transactions therefore always have at least one CS_N-high cycle between them.
- `req_ready` is 0 in every state except IDLE. A requester may keep `req_valid` high and it will be served later. Only one transaction is ever in flight.
- A write never updates `rdata`.

## Timing
- Reset values:
  - OTG_CS_N = OTG_RD_N = OTG_WR_N = 1, OTG_RST_N = 0, OTG_ADDR = 0, OTG_DATA = `'z`.
  - `req_ready` = 0, `req_done` = 0, `rdata` = 0, `int_sync` = 0, `last_grant` = 1 (port 0 wins the first tie).
- Reset asserted mid-transaction: all strobes go to 1 and OTG_DATA goes to `'z` immediately (asynchronously). No `req_done` is issued. The full RST_CYC sequence is repeated.
- Latency: from the acceptance edge to the `req_done` cycle is SETUP_CYC + STROBE_CYC + HOLD_CYC + 1 cycles (7 with defaults).
- Throughput: one transaction per SETUP_CYC + STROBE_CYC + HOLD_CYC + 2 cycles (8 with defaults).
- Phase counter width is `$clog2` of the maximum of the three parameters plus 1. The counter reloads at each state entry and never wraps.
- All HPI outputs come straight from registers, with no combinational path to the pins. The OTG_DATA output enable is also registered.
- `int_sync` lags OTG_INT by 2–3 cycles.

## Structure
- Shared package `hpi_pkg`:
  - `hpi_state_e` enum (RST_HOLD, IDLE, SETUP, STROBE, HOLD, RECOVER).
  - `HPI_NPORTS = 2`.
  - HPI register address constants: DATA = 0, MAILBOX = 1, ADDRESS = 2, STATUS = 3.
- Sub-module `rr_arbiter2`:
  - Inputs: `req[1:0]`, `last_grant`.
  - Output: one-hot `grant[1:0]`.
  - Purely combinational. The FSM and `last_grant` register stay in the parent.

## Test plan
- **Reset release:** Reset low for 5 cycles, then high → OTG_RST_N = 0 for exactly 16 cycles, then 1; `req_ready` = 0 throughout; CS_N/RD_N/WR_N stay 1.
- **Single write:** port 0 writes addr = 2, data = 16'h1234 → CS_N low for 6 cycles, WR_N low for 4 cycles starting one cycle after CS_N; OTG_DATA = 1234 during CS_N low; `req_done[0]` 7 cycles after acceptance.
- **Single read:** port 1 reads addr = 0 while the bench drives OTG_DATA = 16'hBEEF → RD_N low for 4 cycles, `rdata` = BEEF with `req_done[1]`, OTG_DATA never driven by the DUT.
- **Contention:** both ports held valid for 4 transactions → grant order 0, 1, 0, 1; each `req_done` one-hot; CS_N high for at least one cycle between transactions.
- **Reset mid-strobe:** Reset asserted in the 2nd STROBE cycle of a write → WR_N = 1 and OTG_DATA = `'z` with no clock edge needed, no `req_done`, and after release OTG_RST_N is low for 16 cycles before the next grant.
- **Interrupt sync:** OTG_INT rises between clock edges → `int_sync` rises 2–3 cycles later and holds while OTG_INT is high.
